// File: rtl/split_combine_ram_if.sv
// split_combine_ram_if: single-port word memory request/response bus
interface split_combine_ram_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic [WORD_WIDTH-1:0] dout;
    logic                  re;
    logic                  we;
    logic                  ready;

    modport master (output addr, din, re, we, input dout, ready);
    modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/split_combine_ram.sv
// split_combine_ram: two-bank address splitter and combiner in front of a fixed-latency RAM model
module split_combine_ram #(
    parameter int ADDR_WIDTH   = 64,
    parameter int WORD_WIDTH   = 64,
    parameter int SPLIT_OFFSET = 128,
    parameter int RAM_LATENCY  = 100,
    parameter int RAM_DEPTH    = 1024
) (
    input logic clk,
    input logic rst,
    split_combine_ram_if.slave bus
);
    localparam int IW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(RAM_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] OFF = ADDR_WIDTH'(SPLIT_OFFSET);

    logic                  hi, req, sel_q, sel_d;
    logic                  b0_re, b0_we, b1_re, b1_we, b0_req, b1_req;
    logic [ADDR_WIDTH-1:0] b0_addr, b1_addr;
    logic                  b0_ready, b1_ready;
    logic [WORD_WIDTH-1:0] b0_dout, b1_dout;
    logic                  owner_q, owner_d;
    logic                  ram_re, ram_we, ram_ready, ram_acc;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [IW-1:0]         ram_idx, idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic [WORD_WIDTH-1:0] dout_q, dout_d;
    logic [WORD_WIDTH-1:0] mem [RAM_DEPTH];

    // split: route to a bank by address, return the selected bank's response
    assign hi       = bus.addr >= OFF;
    assign req      = bus.re | bus.we;
    assign b0_re    = bus.re & ~hi;
    assign b0_we    = bus.we & ~hi;
    assign b1_re    = bus.re & hi;
    assign b1_we    = bus.we & hi;
    assign b0_addr  = bus.addr;
    assign b1_addr  = bus.addr - OFF;
    assign bus.ready = sel_q ? b1_ready : b0_ready;
    assign bus.dout  = sel_q ? b1_dout : b0_dout;

    // combine: bank 0 has priority; responses go only to the owning bank
    assign b0_req    = b0_re | b0_we;
    assign b1_req    = b1_re | b1_we;
    assign ram_re    = b0_req ? b0_re : b1_re;
    assign ram_we    = b0_req ? b0_we : b1_we;
    assign ram_addr  = b0_req ? b0_addr : b1_addr + OFF;
    assign b0_ready  = ram_ready;
    assign b1_ready  = ram_ready;
    assign b0_dout   = owner_q ? '0 : dout_q;
    assign b1_dout   = owner_q ? dout_q : '0;

    assign ram_ready = cnt_q == '0;
    assign ram_acc   = ram_ready & (ram_re | ram_we);
    assign ram_idx   = IW'(ram_addr % ADDR_WIDTH'(RAM_DEPTH));

    always_comb begin
        sel_d   = (bus.ready & req) ? hi : sel_q;
        owner_d = ram_acc ? (~b0_req & b1_req) : owner_q;
        cnt_d   = ram_acc ? CW'(RAM_LATENCY) : (ram_ready ? cnt_q : cnt_q - CW'(1));
        rd_d    = ram_acc ? (ram_re & ~ram_we) : rd_q;
        idx_d   = ram_acc ? ram_idx : idx_q;
        dout_d  = (cnt_q == CW'(1) && rd_q) ? mem[idx_q] : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            dout_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end

    // storage is never reset; writes land at the accepting edge
    always_ff @(posedge clk) begin
        if (!rst && ram_acc && ram_we) mem[ram_idx] <= bus.din;
    end
endmodule

// File: tb/tb_split_combine_ram.sv
// tb_split_combine_ram: directed self-checking bench for split_combine_ram
module tb_split_combine_ram;
    localparam int L = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;

    split_combine_ram_if bus ();

    split_combine_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        bus.we = w;
        bus.re = ~w;
        bus.addr = a;
        bus.din = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.addr = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.din = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("accept_busy", {63'd0, bus.ready}, 64'd0);
    endtask

    task automatic finish_op(input string tag);
        logic low = 1'b1;
        for (int k = 1; k < L; k++) begin
            @(posedge clk);
            #1;
            bus.we = 1'b0;
            bus.re = 1'b0;
            if (bus.ready !== 1'b0) low = 1'b0;
        end
        chk({tag, "_busy"}, {63'd0, low}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_ready"}, {63'd0, bus.ready}, 64'd1);
    endtask

    initial begin
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.addr = '0;
        bus.din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, bus.ready}, 64'd1);
        chk("reset_dout", bus.dout, 64'd0);

        issue(1'b1, 64'd257, 64'd123);
        finish_op("wr257");
        chk("wr_keeps_dout", bus.dout, 64'd0);
        issue(1'b0, 64'd257, 64'd0);
        finish_op("rd257");
        chk("rd257", bus.dout, 64'd123);

        issue(1'b1, 64'd5, 64'hAAAA);
        finish_op("wr5");
        issue(1'b1, 64'd133, 64'h5555);
        finish_op("wr133");
        issue(1'b0, 64'd5, 64'd0);
        finish_op("rd5");
        chk("rd5", bus.dout, 64'hAAAA);
        issue(1'b0, 64'd133, 64'd0);
        finish_op("rd133");
        chk("rd133", bus.dout, 64'h5555);

        issue(1'b1, 64'd127, 64'h11);
        finish_op("wr127");
        issue(1'b1, 64'd128, 64'h22);
        finish_op("wr128");
        chk("wr_bank0_keeps_dout", bus.dout, 64'h5555);
        issue(1'b0, 64'd127, 64'd0);
        finish_op("rd127");
        chk("rd127", bus.dout, 64'h11);
        issue(1'b0, 64'd128, 64'd0);
        finish_op("rd128");
        chk("rd128", bus.dout, 64'h22);

        issue(1'b1, 64'd1031, 64'd77);
        finish_op("wr1031");
        issue(1'b0, 64'd7, 64'd0);
        finish_op("rd7_alias");
        chk("rd7_alias", bus.dout, 64'd77);

        issue(1'b1, 64'd257, 64'd123);
        @(negedge clk);
        bus.we = 1'b1;
        bus.addr = 64'd257;
        bus.din = 64'd999;
        finish_op("wr257_ignore");
        issue(1'b0, 64'd257, 64'd0);
        finish_op("rd257_again");
        chk("busy_write_ignored", bus.dout, 64'd123);

        issue(1'b0, 64'd133, 64'd0);
        repeat (49) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_ready", {63'd0, bus.ready}, 64'd1);
        chk("midreset_dout", bus.dout, 64'd0);
        #1 rst = 1'b0;
        issue(1'b0, 64'd5, 64'd0);
        finish_op("rd5_after_reset");
        chk("rd5_after_reset", bus.dout, 64'hAAAA);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
